// File: rtl/prog_loader.sv
// prog_loader: UART program loader for the 8-bit CPU's 256-byte program RAM.
//
// Receives a framed program image over an 8N1 serial line, writes it byte by
// byte into RAM through a single write port and holds the CPU in reset while
// a frame is in progress. The CPU is released only after a complete frame.
//
// Frame: 0xA5, LEN, LEN data bytes [, SUM]   (LEN = 0 means 256 bytes)
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   defined   : the trailing SUM byte is expected and compared against the
//               8-bit wrapping sum of the data bytes; a mismatch sets err.
//   undefined : no SUM byte; the CPU is released right after the last data
//               byte and err is set only by a framing error or timeout.
//
// Parameters:
//   CLK_HZ        system clock frequency in Hz
//   BAUD          serial bit rate (bit period DIV = CLK_HZ / BAUD cycles)
//   TIMEOUT_BITS  idle bit periods allowed between bytes of one frame
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-low reset
//   rx         serial input, idle high, asynchronous to clk
//   ram_we     one-cycle RAM write strobe
//   ram_addr   RAM write address (valid with ram_we)
//   ram_wdata  RAM write data (valid with ram_we)
//   cpu_rst_n  active-low reset to the CPU (low while loading / after abort)
//   busy       high while a frame is in progress
//   err        sticky error flag for the last frame
module prog_loader #(
    parameter int CLK_HZ       = 27000000,
    parameter int BAUD         = 115200,
    parameter int TIMEOUT_BITS = 2048
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       ram_we,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_wdata,
    output logic       cpu_rst_n,
    output logic       busy,
    output logic       err
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = $clog2(DIV + 1);
    localparam int TW  = $clog2(TIMEOUT_BITS + 1);

    localparam logic [CW-1:0] DIV_C  = CW'(DIV);
    localparam logic [CW-1:0] HALF_C = CW'(DIV / 2);
    localparam logic [CW-1:0] ONE_C  = CW'(1);
    localparam logic [TW-1:0] TMO_C  = TW'(TIMEOUT_BITS);

    // ------------------------------------------------------------------
    // Input synchronizer plus one extra stage for falling-edge detection
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_sync_q;
    logic rx_prev_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // ------------------------------------------------------------------
    // Byte receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;

    logic            start_det;   // falling edge seen while receiver idle
    logic            byte_done;   // stop bit sampled this cycle
    logic            stop_ok;     // value of that stop bit

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_state_q <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
        end
    end

    // cnt_q counts clocks since the last reference point; the start bit is
    // re-checked half a bit after the edge, so every later sample (DIV apart)
    // lands near the middle of its bit.
    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        start_det  = 1'b0;
        byte_done  = 1'b0;
        stop_ok    = 1'b0;

        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    start_det  = 1'b1;
                    rx_state_d = RX_START;
                    cnt_d      = ONE_C;
                end
            end
            RX_START: begin
                if (cnt_q >= HALF_C) begin
                    cnt_d = ONE_C;
                    bit_d = 3'd0;
                    // line back high at mid start bit: a glitch, not a byte
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            RX_DATA: begin
                if (cnt_q == DIV_C) begin
                    cnt_d   = ONE_C;
                    shift_d = {rx_sync_q, shift_q[7:1]};   // LSB first
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            RX_STOP: begin
                if (cnt_q == DIV_C) begin
                    cnt_d      = '0;
                    byte_done  = 1'b1;
                    stop_ok    = rx_sync_q;
                    rx_state_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
                cnt_d      = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Inter-byte timeout: counts whole idle bit periods while a frame is
    // open. A start edge clears it, and wins over an expiry in the same
    // cycle. The count is frozen while a byte is being shifted in.
    // ------------------------------------------------------------------
    logic [CW-1:0] tick_q;
    logic [TW-1:0] tbits_q;
    logic          timeout;
    logic          busy_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_q  <= '0;
            tbits_q <= '0;
        end else if (!busy_q || start_det) begin
            tick_q  <= '0;
            tbits_q <= '0;
        end else if (rx_state_q == RX_IDLE && tbits_q != TMO_C) begin
            if (tick_q == DIV_C - ONE_C) begin
                tick_q  <= '0;
                tbits_q <= tbits_q + TW'(1);
            end else begin
                tick_q <= tick_q + ONE_C;
            end
        end
    end

    assign timeout = busy_q && (tbits_q == TMO_C) && !start_det;

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        L_IDLE,
        L_LEN,
        L_DATA
`ifdef LOADER_CHECKSUM_EN
        , L_SUM
`endif
    } ld_state_t;

    ld_state_t  state_q, state_d;
    logic [8:0] remain_q, remain_d;     // data bytes still to come, 1..256
    logic [7:0] addr_q, addr_d;         // next RAM index
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;
`endif
    logic       ram_we_q, ram_we_d;
    logic [7:0] ram_addr_q, ram_addr_d;
    logic [7:0] ram_wdata_q, ram_wdata_d;
    logic       cpu_rst_n_q, cpu_rst_n_d;
    logic       busy_d;
    logic       err_q, err_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= L_IDLE;
            remain_q    <= '0;
            addr_q      <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q       <= '0;
`endif
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cpu_rst_n_q <= 1'b1;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remain_q    <= remain_d;
            addr_q      <= addr_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remain_d    = remain_q;
        addr_d      = addr_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        cpu_rst_n_d = cpu_rst_n_q;
        busy_d      = busy_q;
        err_d       = err_q;

        if (state_q != L_IDLE && (timeout || (byte_done && !stop_ok))) begin
            // RAM may already be partly overwritten, so the CPU stays held.
            state_d = L_IDLE;
            busy_d  = 1'b0;
            err_d   = 1'b1;
        end else if (byte_done && stop_ok) begin
            case (state_q)
                L_IDLE: begin
                    if (shift_q == 8'hA5) begin
                        state_d     = L_LEN;
                        busy_d      = 1'b1;
                        err_d       = 1'b0;
                        cpu_rst_n_d = 1'b0;
                    end
                end
                L_LEN: begin
                    remain_d = (shift_q == 8'd0) ? 9'd256 : {1'b0, shift_q};
                    addr_d   = 8'd0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d    = 8'd0;
`endif
                    state_d  = L_DATA;
                end
                L_DATA: begin
                    ram_we_d    = 1'b1;
                    ram_addr_d  = addr_q;
                    ram_wdata_d = shift_q;
                    addr_d      = addr_q + 8'd1;
                    remain_d    = remain_q - 9'd1;
`ifdef LOADER_CHECKSUM_EN
                    sum_d       = sum_q + shift_q;
                    if (remain_q == 9'd1) begin
                        state_d = L_SUM;
                    end
`else
                    if (remain_q == 9'd1) begin
                        state_d     = L_IDLE;
                        busy_d      = 1'b0;
                        cpu_rst_n_d = 1'b1;
                    end
`endif
                end
`ifdef LOADER_CHECKSUM_EN
                L_SUM: begin
                    if (shift_q == sum_q) begin
                        cpu_rst_n_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    busy_d  = 1'b0;
                    state_d = L_IDLE;
                end
`endif
                default: begin
                    state_d = L_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign cpu_rst_n = cpu_rst_n_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: drives 8N1 frames on rx and checks RAM writes
// and status outputs against a frame-level model kept in the bench.
module tb_prog_loader;

    localparam int CLK_HZ       = 1600000;
    localparam int BAUD         = 100000;
    localparam int DIV          = CLK_HZ / BAUD;   // 16 clocks per bit
    localparam int TIMEOUT_BITS = 40;
    localparam int GAP          = 2 * DIV;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       ram_we;
    logic [7:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       cpu_rst_n;
    logic       busy;
    logic       err;

    prog_loader #(
        .CLK_HZ       (CLK_HZ),
        .BAUD         (BAUD),
        .TIMEOUT_BITS (TIMEOUT_BITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        exp_wr[$];     // writes the model expects, in order
    wr_t        wr_log[$];     // writes the DUT actually made
    logic [7:0] m_frame[$];    // bytes of the open frame after 0xA5
    logic       m_busy;
    logic       m_err;
    logic       m_cpu;

    function automatic void model_reset();
        m_busy = 1'b0;
        m_err  = 1'b0;
        m_cpu  = 1'b1;
        m_frame.delete();
        exp_wr.delete();
    endfunction

    function automatic void model_abort();
        m_busy = 1'b0;
        m_err  = 1'b1;
    endfunction

    function automatic void model_byte(input logic [7:0] b, input logic stop_bit);
        int len;
        int unsigned s;
        if (!m_busy) begin
            if (stop_bit && b == 8'hA5) begin
                m_busy = 1'b1;
                m_err  = 1'b0;
                m_cpu  = 1'b0;
                m_frame.delete();
            end
            return;
        end
        if (!stop_bit) begin
            model_abort();
            return;
        end
        m_frame.push_back(b);
        len = (m_frame[0] == 8'd0) ? 256 : int'(m_frame[0]);
        if (m_frame.size() >= 2 && m_frame.size() <= len + 1) begin
            exp_wr.push_back('{a: 8'(m_frame.size() - 2), d: b});
        end
`ifdef LOADER_CHECKSUM_EN
        if (m_frame.size() == len + 2) begin
            s = 0;
            for (int i = 1; i <= len; i++) s += m_frame[i];
            if (8'(s) == b) m_cpu = 1'b1;
            else            m_err = 1'b1;
            m_busy = 1'b0;
        end
`else
        s = 0;
        if (m_frame.size() == len + 1) begin
            m_cpu  = 1'b1;
            m_busy = 1'b0;
        end
`endif
    endfunction

    // ---------------- stimulus helpers ----------------
    int         phase;          // 0 idle/between bytes, 1 start+data bits, 2 stop bit
    logic       skip_status;
    logic [7:0] tx_q[$];

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        phase = 1;
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        phase = 2;
        rx = stop_bit;
        model_byte(b, stop_bit);
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
        phase = 0;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic send_queued();
        while (tx_q.size() != 0) begin
            send_byte(tx_q.pop_front(), 1'b1);
        end
    endtask

    // ---------------- compare process ----------------
    logic we_prev = 1'b0;

    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #2;
            if (ram_we) begin
                check("we_in_stop_bit", 32'(phase == 2), 32'd1);
                check("we_single_cycle", 32'(we_prev), 32'd0);
                wr_log.push_back('{a: ram_addr, d: ram_wdata});
                check("we_expected", 32'(exp_wr.size() != 0), 32'd1);
                if (exp_wr.size() != 0) begin
                    e = exp_wr.pop_front();
                    check("wr_addr", 32'(ram_addr), 32'(e.a));
                    check("wr_data", 32'(ram_wdata), 32'(e.d));
                end
            end
            we_prev = ram_we;
            if (!skip_status && phase != 2) begin
                check("busy", 32'(busy), 32'(m_busy));
                check("err", 32'(err), 32'(m_err));
                check("cpu_rst_n", 32'(cpu_rst_n), 32'(m_cpu));
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int w0;
        int waited;
        rx          = 1'b1;
        rst         = 1'b0;
        phase       = 0;
        skip_status = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);

        // reset values
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b1;
        skip_status = 1'b0;
        repeat (GAP) @(negedge clk);

        // basic load
        w0 = wr_log.size();
        tx_q = '{8'hA5, 8'h03, 8'h12, 8'h34, 8'h56, 8'h9C};
        send_queued();
        check("basic_nwr", 32'(wr_log.size() - w0), 32'd3);
        if (wr_log.size() >= w0 + 3) begin
            check("basic_w0", 32'(wr_log[w0]), 32'h0012);
            check("basic_w1", 32'(wr_log[w0 + 1]), 32'h0134);
            check("basic_w2", 32'(wr_log[w0 + 2]), 32'h0256);
        end
        check("basic_cpu", 32'(cpu_rst_n), 32'd1);
        check("basic_err", 32'(err), 32'd0);

        // bad checksum, then a valid frame
        w0 = wr_log.size();
        tx_q = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h04};
        send_queued();
        check("bad_nwr", 32'(wr_log.size() - w0), 32'd2);
        check("bad_busy", 32'(busy), 32'd0);
`ifdef LOADER_CHECKSUM_EN
        check("bad_err", 32'(err), 32'd1);
        check("bad_cpu", 32'(cpu_rst_n), 32'd0);
`else
        check("bad_err", 32'(err), 32'd0);
        check("bad_cpu", 32'(cpu_rst_n), 32'd1);
`endif
        tx_q = '{8'hA5, 8'h01, 8'h77, 8'h77};
        send_queued();
        check("recover_err", 32'(err), 32'd0);
        check("recover_cpu", 32'(cpu_rst_n), 32'd1);

        // full 256-byte wrap
        w0 = wr_log.size();
        tx_q = '{8'hA5, 8'h00};
        for (int i = 0; i < 256; i++) tx_q.push_back(8'(i));
        tx_q.push_back(8'h80);
        send_queued();
        check("wrap_nwr", 32'(wr_log.size() - w0), 32'd256);
        if (wr_log.size() >= w0 + 256) begin
            check("wrap_last", 32'(wr_log[w0 + 255]), 32'hFFFF);
        end
        check("wrap_cpu", 32'(cpu_rst_n), 32'd1);
        check("wrap_err", 32'(err), 32'd0);

        // garbage and a 0.3-bit glitch in IDLE
        w0 = wr_log.size();
        tx_q = '{8'h00, 8'hFF, 8'h5A};
        send_queued();
        rx = 1'b0;
        repeat (DIV * 3 / 10) @(negedge clk);
        rx = 1'b1;
        repeat (GAP) @(negedge clk);
        check("garbage_nwr", 32'(wr_log.size() - w0), 32'd0);
        check("garbage_busy", 32'(busy), 32'd0);
        check("garbage_cpu", 32'(cpu_rst_n), 32'd1);

        // framing error on a data byte
        w0 = wr_log.size();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h11, 1'b0);
        check("frm_nwr", 32'(wr_log.size() - w0), 32'd0);
        check("frm_err", 32'(err), 32'd1);
        check("frm_cpu", 32'(cpu_rst_n), 32'd0);
        check("frm_busy", 32'(busy), 32'd0);

        // timeout after going silent mid-frame
        tx_q = '{8'hA5, 8'h04, 8'h11};
        send_queued();
        skip_status = 1'b1;
        repeat ((TIMEOUT_BITS - 6) * DIV) @(negedge clk);
        check("tmo_not_early", 32'(busy), 32'd1);
        waited = 0;
        while (busy && waited < 12 * DIV) begin
            @(negedge clk);
            waited++;
        end
        check("tmo_busy", 32'(busy), 32'd0);
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_cpu", 32'(cpu_rst_n), 32'd0);
        model_abort();
        exp_wr.delete();
        skip_status = 1'b0;
        repeat (GAP) @(negedge clk);

        // reset taken mid-frame
        tx_q = '{8'hA5, 8'h04, 8'hAA, 8'hBB};
        send_queued();
        skip_status = 1'b1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mrst_ram_we", 32'(ram_we), 32'd0);
        check("mrst_ram_addr", 32'(ram_addr), 32'd0);
        check("mrst_ram_wdata", 32'(ram_wdata), 32'd0);
        check("mrst_cpu", 32'(cpu_rst_n), 32'd1);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_err", 32'(err), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        skip_status = 1'b0;
        repeat (GAP) @(negedge clk);

        w0 = wr_log.size();
        tx_q = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h30};
        send_queued();
        check("after_nwr", 32'(wr_log.size() - w0), 32'd2);
        if (wr_log.size() >= w0 + 2) begin
            check("after_w1", 32'(wr_log[w0 + 1]), 32'h0120);
        end
        check("after_cpu", 32'(cpu_rst_n), 32'd1);
        check("after_err", 32'(err), 32'd0);

        check("wr_pending", 32'(exp_wr.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
